issue_layer_sequencer: RTL and testbench

//  Sequences the Issue block across a multi-layer network. Holds a small table of layer

---
 rtl/issue_layer_sequencer_pkg.sv | 35 +++
 rtl/issue_layer_sequencer_desc_check.sv | 21 ++
 rtl/issue_layer_sequencer.sv | 156 +++++++++++++++
 tb/tb_issue_layer_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_layer_sequencer_pkg.sv
// Shared types and limits for the Issue layer sequencer: descriptor layout,
// validity bounds and FSM state encoding.
package issue_layer_sequencer_pkg;

    localparam int DESC_W = 22;

    localparam logic [7:0] DIM_MIN   = 8'd13;
    localparam logic [7:0] DIM_MAX   = 8'd224;
    localparam logic [8:0] DEPTH_MIN = 9'd1;
    localparam logic [8:0] DEPTH_MAX = 9'd384;

    // Packed so that a raw 22-bit table word casts directly onto the fields
    typedef struct packed {
        logic [2:0] stride;
        logic [1:0] halfsize;
        logic [8:0] depth;
        logic [7:0] dim;
    } layer_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_ISSUE_RST = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_NEXT      = 3'd5,
        ST_FINISH    = 3'd6
    } seq_state_t;

    // Largest stride that still lets the filter window touch every pixel
    function automatic logic [2:0] max_stride(input logic [1:0] halfsize);
        return {halfsize, 1'b0} + 3'd1;
    endfunction

endpackage

// File: rtl/issue_layer_sequencer_desc_check.sv
// Combinational sanity check of one layer descriptor before it is handed to Issue.
module issue_layer_sequencer_desc_check
    import issue_layer_sequencer_pkg::*;
(
    input  logic [DESC_W-1:0] desc,
    output logic              valid
);

    layer_desc_t d;

    assign d = layer_desc_t'(desc);

    // A descriptor is usable only if every field lies inside the range Issue supports
    always_comb begin
        valid = (d.dim >= DIM_MIN) && (d.dim <= DIM_MAX) &&
                (d.depth >= DEPTH_MIN) && (d.depth <= DEPTH_MAX) &&
                (d.halfsize != 2'd0) && (d.halfsize <= 2'd2) &&
                (d.stride != 3'd0) && (d.stride <= max_stride(d.halfsize));
    end

endmodule

// File: rtl/issue_layer_sequencer.sv
// Walks the Issue block through a table of layer descriptors: load, reset Issue,
// run until done, drain the allocator, then advance and flip the image bank.
module issue_layer_sequencer
    import issue_layer_sequencer_pkg::*;
#(
    parameter int MAX_LAYERS   = 8,
    parameter int LAYER_W      = 3,
    parameter int RST_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [LAYER_W-1:0] cfg_addr,
    input  logic [DESC_W-1:0]  cfg_data,
    input  logic [LAYER_W:0]   cfg_num_layers,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [LAYER_W-1:0] err_layer,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               bank_sel,
    output logic               issue_rst,
    output logic [7:0]         issue_image_dim,
    output logic [8:0]         issue_image_depth,
    output logic [1:0]         issue_filter_halfsize,
    output logic [2:0]         issue_filter_stride,
    input  logic               issue_done
);

    localparam logic [7:0]       RST_LAST   = 8'(RST_CYCLES - 1);
    localparam logic [7:0]       DRAIN_LAST = 8'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
    localparam logic [LAYER_W:0] ONE_N      = (LAYER_W + 1)'(1);

    seq_state_t          state, next_state;
    logic [DESC_W-1:0]   table_mem [MAX_LAYERS];
    logic [LAYER_W:0]    n_layers;
    logic [7:0]          cnt;
    layer_desc_t         cur_desc;
    logic                desc_valid;
    logic                last_layer;
    logic                aborting;

    assign cur_desc   = layer_desc_t'(table_mem[layer_idx]);
    assign last_layer = ({1'b0, layer_idx} == (n_layers - ONE_N));
    assign aborting   = abort && (state != ST_IDLE);

    issue_layer_sequencer_desc_check u_desc_check (
        .desc  (table_mem[layer_idx]),
        .valid (desc_valid)
    );

    // Descriptor table; host writes are only honoured while no sequence is running
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            table_mem[cfg_addr] <= cfg_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; abort overrides everything outside IDLE
    always_comb begin
        next_state = state;
        if (aborting) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (start && !abort) next_state = (cfg_num_layers == '0) ? ST_FINISH : ST_LOAD;
                ST_LOAD:      next_state = desc_valid ? ST_ISSUE_RST : ST_NEXT;
                ST_ISSUE_RST: if (cnt == RST_LAST) next_state = ST_RUN;
                ST_RUN:       if (issue_done) next_state = ST_DRAIN;
                ST_DRAIN:     if (cnt == DRAIN_LAST) next_state = ST_NEXT;
                ST_NEXT:      next_state = last_layer ? ST_FINISH : ST_LOAD;
                ST_FINISH:    next_state = ST_IDLE;
                default:      next_state = ST_IDLE;
            endcase
        end
    end

    // Cycle counter for the timed states, restarted on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (state != next_state) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // Registered control flags, layer bookkeeping and Issue configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy                  <= 1'b0;
            done                  <= 1'b0;
            error                 <= 1'b0;
            err_layer             <= '0;
            layer_idx             <= '0;
            bank_sel              <= 1'b0;
            issue_rst             <= 1'b1;
            n_layers              <= '0;
            issue_image_dim       <= '0;
            issue_image_depth     <= '0;
            issue_filter_halfsize <= '0;
            issue_filter_stride   <= '0;
        end else begin
            done      <= (state == ST_FINISH) && !abort;
            issue_rst <= !((next_state == ST_RUN) || (next_state == ST_DRAIN));
            if (aborting) begin
                busy <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            n_layers  <= cfg_num_layers;
                            layer_idx <= '0;
                            bank_sel  <= 1'b0;
                            error     <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        issue_image_dim       <= cur_desc.dim;
                        issue_image_depth     <= cur_desc.depth;
                        issue_filter_halfsize <= cur_desc.halfsize;
                        issue_filter_stride   <= cur_desc.stride;
                        if (!desc_valid) begin
                            error <= 1'b1;
                            if (!error) err_layer <= layer_idx;
                        end
                    end
                    ST_NEXT: begin
                        if (!last_layer) begin
                            layer_idx <= layer_idx + LAYER_W'(1);
                            bank_sel  <= ~bank_sel;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_issue_layer_sequencer.sv
// Self-checking bench for issue_layer_sequencer: an Issue stub answers each run,
// a scoreboard checks every issue_rst release against the expected layer.
module tb_issue_layer_sequencer;

    localparam int LW       = 3;
    localparam int RSTC     = 2;
    localparam int DRC      = 4;
    localparam int STUB_DLY = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [21:0] cfg_data = '0;
    logic [3:0]  cfg_num_layers = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        issue_done;
    logic        busy, done, error, bank_sel, issue_rst;
    logic [2:0]  err_layer, layer_idx;
    logic [7:0]  dim;
    logic [8:0]  depth;
    logic [1:0]  hs;
    logic [2:0]  stride;

    typedef struct {
        int          idx;
        logic        bank;
        logic [21:0] desc;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ref_cyc = 0;
    int   done_pulses = 0;
    int   stub_cnt = 0;
    logic prev_rst = 1'b1;
    logic prev_idone = 1'b0;
    bit   mon_en = 1'b0;

    logic [21:0] d0, d1, d2, d1_bad, d3_bad;

    issue_layer_sequencer #(
        .MAX_LAYERS   (8),
        .LAYER_W      (LW),
        .RST_CYCLES   (RSTC),
        .DRAIN_CYCLES (DRC)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .cfg_we                (cfg_we),
        .cfg_addr              (cfg_addr),
        .cfg_data              (cfg_data),
        .cfg_num_layers        (cfg_num_layers),
        .start                 (start),
        .abort                 (abort),
        .busy                  (busy),
        .done                  (done),
        .error                 (error),
        .err_layer             (err_layer),
        .layer_idx             (layer_idx),
        .bank_sel              (bank_sel),
        .issue_rst             (issue_rst),
        .issue_image_dim       (dim),
        .issue_image_depth     (depth),
        .issue_filter_halfsize (hs),
        .issue_filter_stride   (stride),
        .issue_done            (issue_done)
    );

    always #5 clk = ~clk;

    // Issue stub: raises done STUB_DLY cycles after reset release, cleared by issue_rst
    always @(posedge clk) begin
        if (issue_rst) begin
            stub_cnt   <= 0;
            issue_done <= 1'b0;
        end else if (stub_cnt == STUB_DLY - 1) begin
            issue_done <= 1'b1;
        end else begin
            stub_cnt <= stub_cnt + 1;
        end
    end

    // Scoreboard monitor: each issue_rst release must match the next expected layer
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (start) ref_cyc = cyc;
        if (issue_done && !prev_idone) ref_cyc = cyc;
        if (done) done_pulses++;
        if (mon_en && rst_n && prev_rst && !issue_rst) begin
            lat_q.push_back(cyc - ref_cyc);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_window: layer_idx=%0d released, none expected", layer_idx);
            end else begin
                e = exp_q.pop_front();
                if (layer_idx !== 3'(e.idx) || bank_sel !== e.bank || {stride, hs, depth, dim} !== e.desc) begin
                    n_fail++;
                    $display("FAIL layer_window: got idx=%0d bank=%0d desc=%h, want idx=%0d bank=%0d desc=%h",
                             layer_idx, bank_sel, {stride, hs, depth, dim}, e.idx, e.bank, e.desc);
                end
            end
        end
        prev_rst   = issue_rst;
        prev_idone = issue_done;
    end

    function automatic logic [21:0] mk(input int dm, input int dp, input int h, input int st);
        return {3'(st), 2'(h), 9'(dp), 8'(dm)};
    endfunction

    function automatic exp_t ex(input int idx, input logic bank, input logic [21:0] desc);
        exp_t e;
        e.idx = idx; e.bank = bank; e.desc = desc;
        return e;
    endfunction

    task automatic write_desc(input int a, input logic [21:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        cfg_num_layers = 4'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits for the done pulse; waited = negedges since start was deasserted
    task automatic wait_done(input int budget, output bit ok, output int waited);
        ok = 1'b0; waited = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; waited = i + 1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, error, bank_sel, issue_rst} !== 5'b00001) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00001", {busy, done, error, bank_sel, issue_rst});
        end
        n_cmp++;
        if ({err_layer, layer_idx} !== 6'd0) begin
            n_fail++; $display("FAIL reset_idx: got %h want 0", {err_layer, layer_idx});
        end
        n_cmp++;
        if ({stride, hs, depth, dim} !== 22'd0) begin
            n_fail++; $display("FAIL reset_cfg: got %h want 0", {stride, hs, depth, dim});
        end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_three_layers();
        bit ok; int w; int dp0;
        write_desc(0, d0); write_desc(1, d1); write_desc(2, d2);
        exp_q.push_back(ex(0, 1'b0, d0));
        exp_q.push_back(ex(1, 1'b1, d1));
        exp_q.push_back(ex(2, 1'b0, d2));
        lat_q.delete(); dp0 = done_pulses;
        pulse_start(3);
        wait_done(1500, ok, w);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL three_done: got no done within budget, want one pulse"); end
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL three_busy_at_done: got %b want 1", busy); end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL three_busy_after: got %b want 0", busy); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL three_windows: %0d layers missing, want 0", exp_q.size()); end
        n_cmp++;
        if (done_pulses - dp0 != 1) begin n_fail++; $display("FAIL three_done_count: got %0d want 1", done_pulses - dp0); end
        n_cmp++;
        if (lat_q.size() != 3) begin
            n_fail++; $display("FAIL three_lat_count: got %0d want 3", lat_q.size());
        end else if (lat_q[0] != 2 + RSTC || lat_q[1] != 3 + DRC + RSTC || lat_q[2] != 3 + DRC + RSTC) begin
            n_fail++; $display("FAIL three_latency: got %0d,%0d,%0d want %0d,%0d,%0d",
                               lat_q[0], lat_q[1], lat_q[2], 2 + RSTC, 3 + DRC + RSTC, 3 + DRC + RSTC);
        end
        n_cmp++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL three_error: got %b want 0", error); end
    endtask

    task automatic test_invalid_layer();
        bit ok; int w; int dp0;
        write_desc(1, d1_bad); write_desc(3, d3_bad);
        exp_q.push_back(ex(0, 1'b0, d0));
        exp_q.push_back(ex(2, 1'b0, d2));
        dp0 = done_pulses;
        pulse_start(4);
        wait_done(1500, ok, w);
        @(negedge clk);
        n_cmp++;
        if (!ok || done_pulses - dp0 != 1) begin
            n_fail++; $display("FAIL inv_done: got ok=%0d pulses=%0d want 1/1", ok, done_pulses - dp0);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL inv_windows: %0d layers missing, want 0", exp_q.size()); end
        n_cmp++;
        if (error !== 1'b1 || err_layer !== 3'd1) begin
            n_fail++; $display("FAIL inv_error: got error=%b err_layer=%0d want 1/1", error, err_layer);
        end
        n_cmp++;
        if ({stride, hs, depth, dim} !== d3_bad || layer_idx !== 3'd3 || bank_sel !== 1'b1) begin
            n_fail++; $display("FAIL inv_hold: got cfg=%h idx=%0d bank=%b want %h/3/1",
                               {stride, hs, depth, dim}, layer_idx, bank_sel, d3_bad);
        end
    endtask

    task automatic test_zero_layers();
        bit ok; int w;
        pulse_start(0);
        wait_done(10, ok, w);
        n_cmp++;
        if (!ok || w != 2) begin n_fail++; $display("FAIL zero_done_latency: got ok=%0d cycles=%0d want 1/2", ok, w); end
        n_cmp++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL zero_error_cleared: got %b want 0", error); end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || issue_rst !== 1'b1) begin
            n_fail++; $display("FAIL zero_idle: got busy=%b issue_rst=%b want 0/1", busy, issue_rst);
        end
    endtask

    task automatic test_abort();
        bit ok; bit found; int w; int dp0;
        write_desc(1, d1);
        exp_q.push_back(ex(0, 1'b0, d0));
        exp_q.push_back(ex(1, 1'b1, d1));
        dp0 = done_pulses;
        pulse_start(3);
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (layer_idx == 3'd1 && !issue_rst) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL abort_reach_run: layer 1 never ran within budget"); end
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_cmp++;
        if (issue_rst !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_response: got issue_rst=%b busy=%b want 1/0", issue_rst, busy);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (done_pulses != dp0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL abort_no_done: got pulses=%0d pending=%0d want 0/0", done_pulses - dp0, exp_q.size());
        end
        @(posedge clk); #1;
        cfg_num_layers = 4'd3; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_idle: got busy=%b want 0", busy); end
        exp_q.push_back(ex(0, 1'b0, d0));
        exp_q.push_back(ex(1, 1'b1, d1));
        exp_q.push_back(ex(2, 1'b0, d2));
        lat_q.delete();
        pulse_start(3);
        wait_done(1500, ok, w);
        @(negedge clk);
        n_cmp++;
        if (!ok || exp_q.size() != 0) begin
            n_fail++; $display("FAIL abort_restart: got ok=%0d pending=%0d want 1/0", ok, exp_q.size());
        end
        n_cmp++;
        if (lat_q.size() < 1 || lat_q[0] != 2 + RSTC) begin
            n_fail++; $display("FAIL restart_latency: got %0d windows first=%0d want first=%0d",
                               lat_q.size(), (lat_q.size() > 0) ? lat_q[0] : -1, 2 + RSTC);
        end
    endtask

    task automatic test_cfg_write_busy();
        bit ok; bit found; int w;
        exp_q.push_back(ex(0, 1'b0, d0));
        pulse_start(1);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!issue_rst) begin found = 1'b1; break; end
        end
        write_desc(0, mk(50, 64, 1, 1));
        @(negedge clk);
        n_cmp++;
        if (!found || dim !== 8'd100) begin
            n_fail++; $display("FAIL cfg_busy_hold: got run=%0d dim=%0d want 1/100", found, dim);
        end
        wait_done(500, ok, w);
        @(negedge clk);
        exp_q.push_back(ex(0, 1'b0, d0));
        pulse_start(1);
        wait_done(500, ok, w);
        @(negedge clk);
        n_cmp++;
        if (!ok || exp_q.size() != 0) begin
            n_fail++; $display("FAIL cfg_busy_dropped: got ok=%0d pending=%0d want 1/0", ok, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        bit found;
        exp_q.push_back(ex(0, 1'b0, d0));
        exp_q.push_back(ex(1, 1'b1, d1));
        pulse_start(2);
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (layer_idx == 3'd1 && issue_done) begin found = 1'b1; break; end
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (!found || {busy, done, error, bank_sel, issue_rst} !== 5'b00001 || layer_idx !== 3'd0) begin
            n_fail++; $display("FAIL async_reset_flags: got drain=%0d flags=%b idx=%0d want 1/00001/0",
                               found, {busy, done, error, bank_sel, issue_rst}, layer_idx);
        end
        n_cmp++;
        if ({stride, hs, depth, dim} !== 22'd0) begin
            n_fail++; $display("FAIL async_reset_cfg: got %h want 0", {stride, hs, depth, dim});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL async_reset_idle: got busy=%b pending=%0d want 0/0", busy, exp_q.size());
        end
    endtask

    initial begin
        d0     = mk(100, 64, 1, 1);
        d1     = mk(224, 384, 2, 5);
        d2     = mk(13, 1, 1, 3);
        d1_bad = mk(100, 64, 2, 6);
        d3_bad = mk(225, 64, 1, 1);
        test_reset();
        test_three_layers();
        test_invalid_layer();
        test_zero_layers();
        test_abort();
        test_cfg_write_busy();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
